proc_ctrl: RTL and testbench



---
 rtl/proc_ctrl_pkg.sv | 14 +
 rtl/proc_ctrl_if.sv | 16 +
 rtl/proc_ctrl_dec2to4.sv | 8 +
 rtl/proc_ctrl.sv | 95 +++++++++
 tb/tb_proc_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: opcodes, state encoding and instruction field slices shared by proc_ctrl
package proc_ctrl_pkg;
  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_T1 = 2'd1, S_T2 = 2'd2, S_T3 = 2'd3} state_t;
  localparam int OP_LSB = 4;
  localparam int RX_LSB = 2;
  localparam int RY_LSB = 0;
  function automatic logic [1:0] fld(input logic [5:0] ir, input int lsb);
    return ir[lsb +: 2];
  endfunction
endpackage

// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: run/ir handshake plus datapath enables; master = instruction source/datapath, slave = proc_ctrl
interface proc_ctrl_if;
  logic       run;
  logic [5:0] ir;
  logic [3:0] r_in;
  logic [3:0] r_out;
  logic       a_in;
  logic       g_in;
  logic       g_out;
  logic       din_out;
  logic       alu_sub;
  logic       busy;
  logic       done;
  modport master (output run, ir, input r_in, r_out, a_in, g_in, g_out, din_out, alu_sub, busy, done);
  modport slave (input run, ir, output r_in, r_out, a_in, g_in, g_out, din_out, alu_sub, busy, done);
endinterface

// File: rtl/proc_ctrl_dec2to4.sv
// dec2to4: 2-bit index to one-hot 4-bit with enable; ports en, idx[1:0], oh[3:0]
module dec2to4 (
  input  logic       en,
  input  logic [1:0] idx,
  output logic [3:0] oh
);
  assign oh = en ? 4'b0001 << idx : 4'b0000;
endmodule

// File: rtl/proc_ctrl.sv
// proc_ctrl: bus-datapath control sequencer; ports clk, rst, bus (proc_ctrl_if.slave), retired[7:0] only with PROC_CTRL_RETIRE_CNT_EN
module proc_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input logic clk,
  input logic rst,
  proc_ctrl_if.slave bus
`ifdef PROC_CTRL_RETIRE_CNT_EN
  ,
  output logic [7:0] retired
`endif
);
  if (DATA_W < 1) begin : g_bad_w
    $error("DATA_W must be positive");
  end
  state_t st_q, st_d;
  logic [5:0] ir_q, ir_d;
  logic [1:0] op_n, rx_n, ry_n, rout_idx_d;
  logic arith, t1, t2, t3, rin_en_d, rout_en_d;
  logic [3:0] r_in_d, r_out_d, r_in_q, r_out_q;
  logic a_in_d, g_in_d, g_out_d, din_out_d, alu_sub_d, busy_d, done_d;
  logic a_in_q, g_in_q, g_out_q, din_out_q, alu_sub_q, busy_q, done_q;
  always_comb begin
    ir_d = (st_q == S_IDLE && bus.run) ? bus.ir : ir_q;
    op_n = fld(ir_d, OP_LSB);
    rx_n = fld(ir_d, RX_LSB);
    ry_n = fld(ir_d, RY_LSB);
    arith = op_n == OP_ADD || op_n == OP_SUB;
    case (st_q)
      S_IDLE:  st_d = bus.run ? S_T1 : S_IDLE;
      S_T1:    st_d = arith ? S_T2 : S_IDLE;
      S_T2:    st_d = S_T3;
      default: st_d = S_IDLE;
    endcase
    t1 = st_d == S_T1;
    t2 = st_d == S_T2;
    t3 = st_d == S_T3;
    rin_en_d = (t1 && !arith) || t3;
    rout_en_d = (t1 && (op_n == OP_MV || arith)) || t2;
    rout_idx_d = (t1 && arith) ? rx_n : ry_n;
    a_in_d = t1 && arith;
    g_in_d = t2;
    alu_sub_d = t2 && op_n == OP_SUB;
    g_out_d = t3;
    din_out_d = t1 && op_n == OP_MVI;
    done_d = rin_en_d;
    busy_d = st_d != S_IDLE;
  end
  dec2to4 u_rin  (.en(rin_en_d),  .idx(rx_n),       .oh(r_in_d));
  dec2to4 u_rout (.en(rout_en_d), .idx(rout_idx_d), .oh(r_out_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      ir_q      <= '0;
      r_in_q    <= '0;
      r_out_q   <= '0;
      a_in_q    <= 1'b0;
      g_in_q    <= 1'b0;
      g_out_q   <= 1'b0;
      din_out_q <= 1'b0;
      alu_sub_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      ir_q      <= ir_d;
      r_in_q    <= r_in_d;
      r_out_q   <= r_out_d;
      a_in_q    <= a_in_d;
      g_in_q    <= g_in_d;
      g_out_q   <= g_out_d;
      din_out_q <= din_out_d;
      alu_sub_q <= alu_sub_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign bus.r_in    = r_in_q;
  assign bus.r_out   = r_out_q;
  assign bus.a_in    = a_in_q;
  assign bus.g_in    = g_in_q;
  assign bus.g_out   = g_out_q;
  assign bus.din_out = din_out_q;
  assign bus.alu_sub = alu_sub_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef PROC_CTRL_RETIRE_CNT_EN
  logic [7:0] retired_q, retired_d;
  always_comb retired_d = retired_q + {7'd0, done_q};
  always_ff @(posedge clk) retired_q <= rst ? 8'd0 : retired_d;
  assign retired = retired_q;
`endif
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: randomized check of proc_ctrl against a step-table model and a shadow register file
module tb_proc_ctrl;
  import proc_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dp_clr = 1'b1;
  logic [2:0] din = 3'd0;
  int vec = 0;
  int bad = 0;
  int ndone = 0;
  logic [2:0] sh [4];
  logic [2:0] dp_r [4];
  logic [2:0] dp_a, dp_g, bus_v;
  always #5 clk = ~clk;
  proc_ctrl_if pif ();
`ifdef PROC_CTRL_RETIRE_CNT_EN
  logic [7:0] retired;
`endif
  proc_ctrl #(.DATA_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(pif)
`ifdef PROC_CTRL_RETIRE_CNT_EN
    ,
    .retired(retired)
`endif
  );
  always_comb begin
    bus_v = 3'd0;
    for (int i = 0; i < 4; i++) if (pif.r_out[i]) bus_v = bus_v | dp_r[i];
    if (pif.g_out) bus_v = bus_v | dp_g;
    if (pif.din_out) bus_v = bus_v | din;
  end
  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 4; i++) dp_r[i] <= 3'd0;
      dp_a <= 3'd0;
      dp_g <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) if (pif.r_in[i]) dp_r[i] <= bus_v;
      if (pif.a_in) dp_a <= bus_v;
      if (pif.g_in) dp_g <= pif.alu_sub ? dp_a - bus_v : dp_a + bus_v;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (!dp_clr) chk("one_drv", 32'($countones(pif.r_out) + int'(pif.g_out) + int'(pif.din_out) <= 1), 32'd1);
  function automatic logic [14:0] ctl_now();
    return {pif.r_in, pif.r_out, pif.a_in, pif.g_in, pif.g_out, pif.din_out, pif.alu_sub, pif.busy, pif.done};
  endfunction
  function automatic logic [14:0] ctl_exp(input logic [1:0] op, input logic [1:0] rx, input logic [1:0] ry, input int s);
    logic [3:0] rin, rout;
    logic a, gi, go, di, su, dn;
    {rin, rout, a, gi, go, di, su, dn} = '0;
    if (s == 1) begin
      if (op == OP_MV) begin rout = 4'b0001 << ry; rin = 4'b0001 << rx; dn = 1'b1; end
      if (op == OP_MVI) begin di = 1'b1; rin = 4'b0001 << rx; dn = 1'b1; end
      if (op[1]) begin rout = 4'b0001 << rx; a = 1'b1; end
    end else if (s == 2) begin
      rout = 4'b0001 << ry;
      gi = 1'b1;
      su = op == OP_SUB;
    end else begin
      go = 1'b1;
      rin = 4'b0001 << rx;
      dn = 1'b1;
    end
    return {rin, rout, a, gi, go, di, su, 1'b1, dn};
  endfunction
  task automatic issue(input logic [1:0] op, input logic [1:0] rx, input logic [1:0] ry, input logic [2:0] d);
    logic [2:0] e;
    int n;
    e = op == OP_MV ? sh[ry] : op == OP_MVI ? d : op == OP_ADD ? 3'(sh[rx] + sh[ry]) : 3'(sh[rx] - sh[ry]);
    n = op[1] ? 3 : 1;
    pif.ir = {op, rx, ry};
    pif.run = 1'b1;
    din = d;
    for (int s = 1; s <= n; s++) begin
      @(negedge clk);
      chk("step", 32'(ctl_now()), 32'(ctl_exp(op, rx, ry, s)));
      pif.run = 1'($urandom);
      pif.ir = 6'($urandom);
    end
    @(negedge clk);
    chk("idle", 32'(ctl_now()), 32'd0);
    chk("reg", 32'(dp_r[rx]), 32'(e));
    sh[rx] = e;
    ndone++;
    pif.run = 1'b0;
`ifdef PROC_CTRL_RETIRE_CNT_EN
    chk("retired", 32'(retired), 32'(ndone % 256));
`endif
  endtask
  initial begin
    for (int i = 0; i < 4; i++) sh[i] = 3'd0;
    pif.run = 1'b1;
    pif.ir = 6'h2a;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ctl", 32'(ctl_now()), 32'd0);
    end
    rst = 1'b0;
    dp_clr = 1'b0;
    pif.run = 1'b0;
`ifdef PROC_CTRL_RETIRE_CNT_EN
    chk("retired_rst", 32'(retired), 32'd0);
`endif
    issue(OP_MVI, 2'd2, 2'd0, 3'b101);
    issue(OP_MV,  2'd0, 2'd2, 3'd0);
    chk("r0_mv", 32'(dp_r[0]), 32'd5);
    issue(OP_MVI, 2'd1, 2'd0, 3'b011);
    issue(OP_MVI, 2'd3, 2'd0, 3'b010);
    issue(OP_ADD, 2'd1, 2'd3, 3'd0);
    chk("r1_add", 32'(dp_r[1]), 32'd5);
    issue(OP_MVI, 2'd0, 2'd0, 3'b110);
    issue(OP_SUB, 2'd0, 2'd0, 3'd0);
    chk("r0_sub", 32'(dp_r[0]), 32'd0);
    issue(OP_MVI, 2'd2, 2'd0, 3'b111);
    issue(OP_MVI, 2'd3, 2'd0, 3'b001);
    issue(OP_ADD, 2'd2, 2'd3, 3'd0);
    chk("r2_wrap", 32'(dp_r[2]), 32'd0);
    issue(OP_MV,  2'd1, 2'd1, 3'd0);
    for (int k = 0; k < 300; k++) issue(2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom));
    pif.ir = {OP_SUB, 2'd1, 2'd2};
    pif.run = 1'b1;
    @(negedge clk);
    chk("abort_t1", 32'(ctl_now()), 32'(ctl_exp(OP_SUB, 2'd1, 2'd2, 1)));
    @(negedge clk);
    chk("abort_t2", 32'(ctl_now()), 32'(ctl_exp(OP_SUB, 2'd1, 2'd2, 2)));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctl", 32'(ctl_now()), 32'd0);
    chk("abort_reg", 32'(dp_r[1]), 32'(sh[1]));
`ifdef PROC_CTRL_RETIRE_CNT_EN
    chk("retired_abort", 32'(retired), 32'd0);
`endif
    rst = 1'b0;
    pif.run = 1'b0;
    ndone = 0;
    @(negedge clk);
    chk("abort_idle", 32'(ctl_now()), 32'd0);
    chk("abort_reg2", 32'(dp_r[1]), 32'(sh[1]));
    issue(OP_MVI, 2'd1, 2'd0, 3'b100);
    issue(OP_SUB, 2'd1, 2'd2, 3'd0);
    issue(OP_ADD, 2'd3, 2'd1, 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
